// File: rtl/turn_scheduler.sv
// Turn-order scheduler: menu -> player -> enemy rounds, plus a four-phase game-over
// animation timed by frame ticks. Define TURN_SCHEDULER_FADE_EN for a gradual text fade-in.
module turn_scheduler #(
  parameter int unsigned IDLE_FRAMES    = 60,
  parameter int unsigned SPLIT_FRAMES   = 120,
  parameter int unsigned SHATTER_FRAMES = 60,
  parameter int unsigned FADE_DIV       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_in,
  input  logic        menu_done_in,
  input  logic        player_done_in,
  input  logic        enemy_done_in,
  input  logic        game_over_in,
  output logic [3:0]  state_out,
  output logic        round_rst_out,
  output logic [1:0]  anim_phase_out,
  output logic        divided_out,
  output logic        fall_apart_valid_out,
  output logic [11:0] font_color_out
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    ST_MENU      = 4'b0000,
    ST_PLAYER    = 4'b0001,
    ST_ENEMY     = 4'b1000,
    ST_GAME_OVER = 4'b1111
  } state_e;

  if (FADE_DIV == 0) begin : g_bad_fade_div
    $error("turn_scheduler: FADE_DIV must be non-zero");
  end

  state_e           state_q, state_d;
  logic             round_rst_q, round_rst_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             divided_q, divided_d;
  logic             fall_q, fall_d;
  logic [3:0]       nib_q, nib_d;
  logic             menu_prev_q, player_prev_q, enemy_prev_q, go_prev_q;

  logic             menu_rise, player_rise, enemy_rise, go_rise;
  logic [CNT_W-1:0] frame_cnt_inc;

`ifdef TURN_SCHEDULER_FADE_EN
  logic [CNT_W-1:0] fade_cnt_q, fade_cnt_d;
  logic [CNT_W-1:0] fade_cnt_inc;
  assign fade_cnt_inc = fade_cnt_q + CNT_W'(1);
`endif

  assign menu_rise     = menu_done_in   & ~menu_prev_q;
  assign player_rise   = player_done_in & ~player_prev_q;
  assign enemy_rise    = enemy_done_in  & ~enemy_prev_q;
  assign go_rise       = game_over_in   & ~go_prev_q;
  assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);

  // Next-state: game-over edge wins over any done edge in the same cycle.
  always_comb begin
    state_d     = state_q;
    round_rst_d = 1'b0;
    phase_d     = phase_q;
    frame_cnt_d = frame_cnt_q;
    nib_d       = nib_q;
`ifdef TURN_SCHEDULER_FADE_EN
    fade_cnt_d  = fade_cnt_q;
`endif
    if (state_q != ST_GAME_OVER && go_rise) begin
      state_d     = ST_GAME_OVER;
      phase_d     = 2'd0;
      frame_cnt_d = '0;
      nib_d       = 4'h0;
`ifdef TURN_SCHEDULER_FADE_EN
      fade_cnt_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_MENU:   if (menu_rise)   state_d = ST_PLAYER;
        ST_PLAYER: if (player_rise) state_d = ST_ENEMY;
        ST_ENEMY: begin
          if (enemy_rise) begin
            state_d     = ST_MENU;
            round_rst_d = 1'b1;
          end
        end
        ST_GAME_OVER: begin
          if (frame_tick_in) begin
            case (phase_q)
              2'd0: begin
                if (frame_cnt_inc == CNT_W'(IDLE_FRAMES)) begin
                  phase_d     = 2'd1;
                  frame_cnt_d = '0;
                end else frame_cnt_d = frame_cnt_inc;
              end
              2'd1: begin
                if (frame_cnt_inc == CNT_W'(SPLIT_FRAMES)) begin
                  phase_d     = 2'd2;
                  frame_cnt_d = '0;
                end else frame_cnt_d = frame_cnt_inc;
              end
              2'd2: begin
                if (frame_cnt_inc == CNT_W'(SHATTER_FRAMES)) begin
                  phase_d     = 2'd3;
                  frame_cnt_d = '0;
                end else frame_cnt_d = frame_cnt_inc;
              end
              default: begin
`ifdef TURN_SCHEDULER_FADE_EN
                if (fade_cnt_inc == CNT_W'(FADE_DIV)) begin
                  fade_cnt_d = '0;
                  if (nib_q != 4'hF) nib_d = nib_q + 4'h1;
                end else fade_cnt_d = fade_cnt_inc;
`endif
              end
            endcase
          end
        end
        default: state_d = ST_MENU;
      endcase
    end
`ifndef TURN_SCHEDULER_FADE_EN
    nib_d = (phase_d == 2'd3) ? 4'hF : 4'h0;
`endif
    divided_d = (phase_d != 2'd0);
    fall_d    = phase_d[1];
  end

  // Edge-history registers track inputs even in reset so held levels never count as edges.
  always_ff @(posedge clk) begin
    menu_prev_q   <= menu_done_in;
    player_prev_q <= player_done_in;
    enemy_prev_q  <= enemy_done_in;
    go_prev_q     <= game_over_in;
    if (!rst) begin
      state_q     <= ST_MENU;
      round_rst_q <= 1'b0;
      phase_q     <= 2'd0;
      frame_cnt_q <= '0;
      divided_q   <= 1'b0;
      fall_q      <= 1'b0;
      nib_q       <= 4'h0;
`ifdef TURN_SCHEDULER_FADE_EN
      fade_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      round_rst_q <= round_rst_d;
      phase_q     <= phase_d;
      frame_cnt_q <= frame_cnt_d;
      divided_q   <= divided_d;
      fall_q      <= fall_d;
      nib_q       <= nib_d;
`ifdef TURN_SCHEDULER_FADE_EN
      fade_cnt_q  <= fade_cnt_d;
`endif
    end
  end

  assign state_out            = state_q;
  assign round_rst_out        = round_rst_q;
  assign anim_phase_out       = phase_q;
  assign divided_out          = divided_q;
  assign fall_apart_valid_out = fall_q;
  assign font_color_out       = {nib_q, nib_q, nib_q};

endmodule
